serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_rx.sv | 165 ++++++++++++++++
 tb/tb_serial_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define SERIAL_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module serial_rx #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115200
) (
  input  logic       clk,
  input  logic       reset_button,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_error,
  output logic       RxD_idle,
  output logic [1:0] rx_state
);

  localparam int BIT  = comm_clk_frequency / baud_rate;
  localparam int HALF = BIT / 2;
  localparam int CW   = (BIT > 2) ? $clog2(BIT) : 1;
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [1:0]      fill_q, fill_d;
  logic            armed_q, armed_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            brk_q, brk_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic            idle_q, idle_d;
  logic            rxs, expiry, act, sample;
`ifdef SERIAL_RX_MAJORITY_EN
  logic [1:0]      hist_q, hist_d;
  logic            pend_q, pend_d;
`endif

  // RxD_data_ready / RxD_frame_error are single-cycle strobes with no back-pressure:
  // RxD_data is valid in the ready cycle and holds until the next good frame.
  always_comb begin
    rxs    = sync2_q;
    expiry = (state_q != IDLE) && (cnt_q == '0);
`ifdef SERIAL_RX_MAJORITY_EN
    // Act one cycle after expiry so the sample at expiry+1 can join the vote.
    act    = pend_q;
    sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
    pend_d = expiry;
    hist_d = {hist_q[0], rxs};
`else
    act    = expiry;
    sample = rxs;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
    fill_d  = {fill_q[0], 1'b1};
    // After reset, only arm once the real line has been seen high.
    armed_d = armed_q | (fill_q[1] & rxs);
    if (state_q != IDLE) cnt_d = expiry ? BIT_M1 : cnt_q - CW'(1);
    case (state_q)
      IDLE: begin
        if (armed_q && !rxs) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (act) begin
          if (!sample) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (act) begin
          shift_d[idx_q] = sample;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            brk_d   = 1'b0;
          end
        end
      end
      STOP: begin
        if (brk_q) begin
          if (rxs) begin
            state_d = IDLE;
            brk_d   = 1'b0;
          end
        end else if (act) begin
          if (sample) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      brk_q   <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      idle_q  <= 1'b1;
`ifdef SERIAL_RX_MAJORITY_EN
      hist_q  <= 2'b11;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= RxD;
      sync2_q <= sync1_q;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      idle_q  <= idle_d;
`ifdef SERIAL_RX_MAJORITY_EN
      hist_q  <= hist_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign RxD_data        = data_q;
  assign RxD_data_ready  = ready_q;
  assign RxD_frame_error = ferr_q;
  assign RxD_idle        = idle_q;
  assign rx_state        = state_q;

endmodule

// File: tb/tb_serial_rx.sv
// Randomized and directed bench for serial_rx; expected events come from a
// frame-level model (byte + stop bit -> data/error event and its latency).
module tb_serial_rx;
  localparam int BIT  = 434;
  localparam int HALF = 217;
`ifdef SERIAL_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
  localparam int LAT = 4127;
`else
  localparam bit MAJ = 1'b0;
  localparam int LAT = 4126;
`endif

  logic       clk = 1'b0;
  logic       reset_button;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_error;
  logic       RxD_idle;
  logic [1:0] rx_state;

  serial_rx dut (
    .clk             (clk),
    .reset_button    (reset_button),
    .RxD             (RxD),
    .RxD_data        (RxD_data),
    .RxD_data_ready  (RxD_data_ready),
    .RxD_frame_error (RxD_frame_error),
    .RxD_idle        (RxD_idle),
    .rx_state        (rx_state)
  );

  // clock / reset
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {is_error, RxD_data} per frame, plus the start-edge cycle
  logic [8:0] exp_q[$];
  int         t_q[$];
  logic [7:0] last_good;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] e;
  int         t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    int st;
    logic [7:0] rx_byte;
    st = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (glitch) begin
        drive(d[i], HALF);
        drive(~d[i], 1);
        drive(d[i], BIT - HALF - 1);
      end else begin
        drive(d[i], BIT);
      end
    end
    rx_byte = (glitch && !MAJ) ? ~d : d;
    if (stop) begin
      exp_q.push_back({1'b0, rx_byte});
      last_good = rx_byte;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    t_q.push_back(st);
    drive(stop, BIT);
  endtask

  task automatic check_reset_values();
    check("rst_data", RxD_data, 8'h00);
    check("rst_ready", RxD_data_ready, 1'b0);
    check("rst_ferr", RxD_frame_error, 1'b0);
    check("rst_idle", RxD_idle, 1'b1);
    check("rst_state", rx_state, 2'd0);
  endtask

  // monitor: every strobe must match the next expected frame event
  always @(negedge clk) begin
    if (RxD_data_ready && RxD_frame_error) check("excl_pulses", 1, 0);
    if (RxD_data_ready || RxD_frame_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {RxD_data_ready, RxD_frame_error}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        t = t_q.pop_front();
        check("event_kind", RxD_frame_error, e[8]);
        check("event_data", RxD_data, e[7:0]);
        check("latency", cyc - t, LAT);
      end
    end
  end

  initial begin
    logic [7:0] partial;
    logic [7:0] rd;
    logic       rs;
    int         gap;
    reset_button = 1'b0;
    RxD          = 1'b1;
    last_good    = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_values();
    reset_button = 1'b1;
    drive(1'b1, 20);

    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 50);
    check("data_a5", RxD_data, 8'hA5);

    // false start: 100 clk low, back to IDLE after the half-bit check
    drive(1'b0, 100);
    check("fs_busy_low", RxD_idle, 1'b0);
    drive(1'b1, 100);
    check("fs_busy_mid", RxD_idle, 1'b0);
    drive(1'b1, 30);
    check("fs_idle", RxD_idle, 1'b1);
    check("fs_data", RxD_data, 8'hA5);

    // framing error with a long break, then recovery
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    drive(1'b0, 1000);
    drive(1'b1, 20);
    check("ferr_hold", RxD_data, 8'h3C);
    send_frame(8'h11, 1'b1, 1'b0);
    drive(1'b1, 10);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    drive(1'b1, 10);
    check("b2b_last", RxD_data, 8'h55);

    // reset during bit 4 of 0xF0
    partial = 8'hF0;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(partial[i], BIT);
    drive(partial[4], HALF);
    reset_button = 1'b0;
    last_good    = 8'h00;
    drive(partial[4], 3);
    check_reset_values();
    reset_button = 1'b1;
    drive(1'b1, 4 * BIT);
    check("post_rst_data", RxD_data, 8'h00);
    send_frame(8'h81, 1'b1, 1'b0);
    drive(1'b1, 10);

    // one-clk glitch at each data-bit centre
    send_frame(8'hC3, 1'b1, 1'b1);
    drive(1'b1, 10);
    check("glitch_data", RxD_data, MAJ ? 8'hC3 : 8'h3C);

    for (int k = 0; k < 5; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(rs ? 0 : 4, 40);
      send_frame(rd, rs, 1'b0);
      drive(1'b1, gap);
    end

    drive(1'b1, 600);
    check("leftover_events", exp_q.size(), 0);
    check("final_idle", RxD_idle, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
